// File: rtl/ncc_pkg.sv
// Shared types and constants for the normalized-cross-correlation scorer.
package ncc_pkg;

    localparam int DIM       = 16;
    localparam int PIX_W     = 8;
    localparam int IDX_W     = 9;
    localparam int FRAC_W    = 54;
    localparam int WORDS     = DIM * DIM / 4;
    localparam int DIV_STEPS = 64;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t row_t [DIM];
    typedef bit [9:-FRAC_W] score_t;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        SUM,
        MUL,
        DIV,
        CMP
    } state_t;

endpackage

// File: rtl/ncc_if.sv
// Bus between the tracker front end (master) and the NCC scorer (slave).
interface ncc_if;
    import ncc_pkg::*;

    logic                 window_data_ready;
    logic                 desc_data_ready;
    logic [31:0]          descIn;
    row_t                 windowIn [DIM];
    logic                 done_with_window_data;
    logic                 done_with_desc_data;
    score_t               greatestNCC;
    logic [IDX_W-1:0]     greatestWinIndex;
    logic [31:0]          accRowTotal [DIM];

    modport master (
        output window_data_ready, desc_data_ready, descIn, windowIn,
        input  done_with_window_data, done_with_desc_data,
               greatestNCC, greatestWinIndex, accRowTotal
    );

    modport slave (
        input  window_data_ready, desc_data_ready, descIn, windowIn,
        output done_with_window_data, done_with_desc_data,
               greatestNCC, greatestWinIndex, accRowTotal
    );

endinterface

// File: rtl/ncc_row_pe.sv
// One row of the correlator: descriptor/window dot product and window energy.
module ncc_row_pe
    import ncc_pkg::*;
(
    input  row_t        descRow_i,
    input  row_t        winRow_i,
    output logic [31:0] dot_o,
    output logic [31:0] winSq_o
);

    // 16-way multiply-accumulate across the columns of one row
    always_comb begin
        dot_o   = '0;
        winSq_o = '0;
        for (int c = 0; c < DIM; c++) begin
            dot_o   = dot_o + 32'(descRow_i[c]) * 32'(winRow_i[c]);
            winSq_o = winSq_o + 32'(winRow_i[c]) * 32'(winRow_i[c]);
        end
    end

endmodule

// File: rtl/ncc.sv
// NCC scorer: loads a descriptor patch, scores candidate windows against it
// and keeps the best squared-NCC score with the index of its window.
module ncc
    import ncc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ncc_if.slave bus
);

    state_t           state_q, state_d;
    logic [5:0]       wordCnt_q, wordCnt_d;
    logic [IDX_W-1:0] winCnt_q, winCnt_d;
    row_t             desc_q [DIM];
    row_t             desc_d [DIM];
    row_t             win_q [DIM];
    row_t             win_d [DIM];
    logic [31:0]      descSos_q, descSos_d;
    logic [31:0]      accRow_q [DIM];
    logic [31:0]      accRow_d [DIM];
    logic [31:0]      rowSq_q [DIM];
    logic [31:0]      rowSq_d [DIM];
    logic [31:0]      patchSum_q, patchSum_d;
    logic [31:0]      winSos_q, winSos_d;
    logic [63:0]      den_q, den_d;
    logic [63:0]      rem_q, rem_d;
    logic [63:0]      divLow_q, divLow_d;
    logic [63:0]      quot_q, quot_d;
    logic [5:0]       divCnt_q, divCnt_d;
    score_t           best_q, best_d;
    logic [IDX_W-1:0] bestIdx_q, bestIdx_d;
    logic             doneWin_q, doneWin_d;
    logic             doneDesc_q, doneDesc_d;

    logic [31:0]      peDot [DIM];
    logic [31:0]      peSq [DIM];
    logic [31:0]      descSq;
    logic [47:0]      numProd;
    logic [64:0]      remShift;
    score_t           score;

    for (genvar r = 0; r < DIM; r++) begin : gRow
        ncc_row_pe uPe (
            .descRow_i (desc_q[r]),
            .winRow_i  (win_q[r]),
            .dot_o     (peDot[r]),
            .winSq_o   (peSq[r])
        );
    end

    // Energy of the four descriptor pixels arriving this cycle
    always_comb begin
        descSq = '0;
        for (int i = 0; i < 4; i++) begin
            descSq = descSq + 32'(bus.descIn[8*i +: 8]) * 32'(bus.descIn[8*i +: 8]);
        end
    end

    // The quotient never exceeds 1.0, so the top of (num << 54) can seed the
    // remainder directly and only 64 quotient bits need to be produced.
    assign numProd  = 48'(patchSum_q) * 48'(patchSum_q);
    assign remShift = {rem_q, divLow_q[63]};
    assign score    = (den_q == '0) ? score_t'(0) : score_t'(quot_q);

    // Next-state logic: descriptor loading has priority and aborts any window
    always_comb begin
        state_d    = state_q;
        wordCnt_d  = wordCnt_q;
        winCnt_d   = winCnt_q;
        desc_d     = desc_q;
        win_d      = win_q;
        descSos_d  = descSos_q;
        accRow_d   = accRow_q;
        rowSq_d    = rowSq_q;
        patchSum_d = patchSum_q;
        winSos_d   = winSos_q;
        den_d      = den_q;
        rem_d      = rem_q;
        divLow_d   = divLow_q;
        quot_d     = quot_q;
        divCnt_d   = divCnt_q;
        best_d     = best_q;
        bestIdx_d  = bestIdx_q;
        doneWin_d  = 1'b0;
        doneDesc_d = 1'b0;

        if (bus.desc_data_ready) begin
            for (int i = 0; i < 4; i++) begin
                desc_d[wordCnt_q[5:2]][{wordCnt_q[1:0], 2'(i)}] = bus.descIn[31-8*i -: 8];
            end
            descSos_d = (wordCnt_q == '0) ? descSq : descSos_q + descSq;
            state_d   = IDLE;
            if (wordCnt_q == 6'(WORDS - 1)) begin
                wordCnt_d  = '0;
                doneDesc_d = 1'b1;
                best_d     = '0;
                bestIdx_d  = '0;
                winCnt_d   = '0;
            end else begin
                wordCnt_d = wordCnt_q + 6'd1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.window_data_ready) begin
                        win_d   = bus.windowIn;
                        state_d = ROW;
                    end
                end
                ROW: begin
                    accRow_d = peDot;
                    rowSq_d  = peSq;
                    state_d  = SUM;
                end
                SUM: begin
                    patchSum_d = '0;
                    winSos_d   = '0;
                    for (int r = 0; r < DIM; r++) begin
                        patchSum_d = patchSum_d + accRow_q[r];
                        winSos_d   = winSos_d + rowSq_q[r];
                    end
                    state_d = MUL;
                end
                MUL: begin
                    den_d    = 64'(descSos_q) * 64'(winSos_q);
                    rem_d    = 64'(numProd[47:10]);
                    divLow_d = {numProd[9:0], 54'd0};
                    quot_d   = '0;
                    divCnt_d = '0;
                    state_d  = DIV;
                end
                DIV: begin
                    if (remShift >= {1'b0, den_q}) begin
                        rem_d  = remShift[63:0] - den_q;
                        quot_d = {quot_q[62:0], 1'b1};
                    end else begin
                        rem_d  = remShift[63:0];
                        quot_d = {quot_q[62:0], 1'b0};
                    end
                    divLow_d = {divLow_q[62:0], 1'b0};
                    divCnt_d = divCnt_q + 6'd1;
                    if (divCnt_q == 6'(DIV_STEPS - 1)) begin
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (score > best_q) begin
                        best_d    = score;
                        bestIdx_d = winCnt_q;
                    end
                    winCnt_d  = winCnt_q + 1'b1;
                    doneWin_d = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wordCnt_q  <= '0;
            winCnt_q   <= '0;
            desc_q     <= '{default: '0};
            win_q      <= '{default: '0};
            descSos_q  <= '0;
            accRow_q   <= '{default: '0};
            rowSq_q    <= '{default: '0};
            patchSum_q <= '0;
            winSos_q   <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            divLow_q   <= '0;
            quot_q     <= '0;
            divCnt_q   <= '0;
            best_q     <= '0;
            bestIdx_q  <= '0;
            doneWin_q  <= 1'b0;
            doneDesc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wordCnt_q  <= wordCnt_d;
            winCnt_q   <= winCnt_d;
            desc_q     <= desc_d;
            win_q      <= win_d;
            descSos_q  <= descSos_d;
            accRow_q   <= accRow_d;
            rowSq_q    <= rowSq_d;
            patchSum_q <= patchSum_d;
            winSos_q   <= winSos_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            divLow_q   <= divLow_d;
            quot_q     <= quot_d;
            divCnt_q   <= divCnt_d;
            best_q     <= best_d;
            bestIdx_q  <= bestIdx_d;
            doneWin_q  <= doneWin_d;
            doneDesc_q <= doneDesc_d;
        end
    end

    assign bus.done_with_window_data = doneWin_q;
    assign bus.done_with_desc_data   = doneDesc_q;
    assign bus.greatestNCC           = best_q;
    assign bus.greatestWinIndex      = bestIdx_q;
    assign bus.accRowTotal           = accRow_q;

endmodule

// File: tb/tb_ncc.sv
// Testbench for ncc: random and directed windows scored against a
// plain-arithmetic reference model, checked through a scoreboard.
module tb_ncc;
    import ncc_pkg::*;

    typedef struct packed {
        logic [63:0]           ncc;
        logic [31:0]           idx;
        logic [31:0]           issue;
        logic [DIM-1:0][31:0]  rows;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ncc_if bus();

    ncc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cycleCnt = 0;
    exp_t        expQ[$];
    int          descQ[$];
    row_t        curWin [DIM];
    row_t        curPat [DIM];
    row_t        mDesc [DIM];
    logic [63:0] mBest;
    int          mIdx;
    int          mWinCnt;

    // Free-running cycle count used for latency checks
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, got, want);
        end
    endtask

    task automatic flagFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: actual=pulse required=none", name);
    endtask

    // Monitor: compare each completion pulse against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done_with_window_data === 1'b1) begin
                if (expQ.size() == 0) begin
                    flagFail("unexpectedWindowDone");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("greatestNCC", 64'(bus.greatestNCC), e.ncc);
                    checkOutput("greatestWinIndex", 64'(bus.greatestWinIndex), 64'(e.idx));
                    checkOutput("windowLatency", 64'(cycleCnt - int'(e.issue)), 64'd69);
                    for (int r = 0; r < DIM; r++) begin
                        checkOutput($sformatf("accRowTotal[%0d]", r), 64'(bus.accRowTotal[r]), 64'(e.rows[r]));
                    end
                end
            end
            if (bus.done_with_desc_data === 1'b1) begin
                if (descQ.size() == 0) begin
                    flagFail("unexpectedDescDone");
                end else begin
                    checkOutput("descDoneCycle", 64'(cycleCnt), 64'(descQ.pop_front()));
                end
            end
        end
    end

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || descQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (expQ.size() != 0 || descQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drainTimeout: actual=%0d pending required=0 pending", expQ.size() + descQ.size());
            expQ.delete();
            descQ.delete();
        end
    endtask

    // mode 0: constant v, mode 1: descriptor pattern times v, mode 2: random
    task automatic fillWin(input int mode, input int v);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                case (mode)
                    0:       curWin[r][c] = 8'(v);
                    1:       curWin[r][c] = 8'(int'(curPat[r][c]) * v);
                    default: curWin[r][c] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic loadDescriptor(input int gapAt);
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            if (k == gapAt) begin
                bus.desc_data_ready = 1'b0;
                repeat (3) @(negedge clk);
            end
            bus.desc_data_ready = 1'b1;
            bus.descIn = {curPat[k/4][4*(k%4)], curPat[k/4][4*(k%4)+1],
                          curPat[k/4][4*(k%4)+2], curPat[k/4][4*(k%4)+3]};
            if (k == WORDS - 1) descQ.push_back(cycleCnt + 1);
        end
        @(negedge clk);
        bus.desc_data_ready = 1'b0;
        mDesc   = curPat;
        mBest   = '0;
        mIdx    = 0;
        mWinCnt = 0;
    endtask

    // Present curWin; when the window is expected to complete, score it with
    // the reference model: dot^2 * 2^54 / (descEnergy * winEnergy)
    task automatic applyStimulus(input bit expectDone);
        exp_t            e;
        longint unsigned dot, ds, ws, p, num, den;
        logic [127:0]    q;
        logic [63:0]     sc;
        @(negedge clk);
        bus.windowIn = curWin;
        bus.window_data_ready = 1'b1;
        if (expectDone) begin
            dot = 0; ds = 0; ws = 0;
            e.rows = '0;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    p = longint'(mDesc[r][c]) * longint'(curWin[r][c]);
                    e.rows[r] = e.rows[r] + 32'(p);
                    dot += p;
                    ds  += longint'(mDesc[r][c]) * longint'(mDesc[r][c]);
                    ws  += longint'(curWin[r][c]) * longint'(curWin[r][c]);
                end
            end
            num = dot * dot;
            den = ds * ws;
            if (den == 0) begin
                sc = '0;
            end else begin
                q  = ({64'd0, num} << FRAC_W) / {64'd0, den};
                sc = q[63:0];
            end
            if (sc > mBest) begin
                mBest = sc;
                mIdx  = mWinCnt;
            end
            mWinCnt = (mWinCnt + 1) % 512;
            e.ncc   = mBest;
            e.idx   = 32'(mIdx);
            e.issue = 32'(cycleCnt);
            expQ.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.window_data_ready = 1'b0;
    endtask

    task automatic strayPulse();
        @(negedge clk);
        bus.window_data_ready = 1'b1;
        @(negedge clk);
        bus.window_data_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.window_data_ready = 1'b0;
        bus.desc_data_ready   = 1'b0;
        bus.descIn            = '0;
        fillWin(0, 0);
        bus.windowIn = curWin;
        mDesc   = curWin;
        mBest   = '0;
        mIdx    = 0;
        mWinCnt = 0;

        repeat (3) @(negedge clk);
        checkOutput("resetNCC", 64'(bus.greatestNCC), 64'd0);
        checkOutput("resetIndex", 64'(bus.greatestWinIndex), 64'd0);
        checkOutput("resetDoneWin", 64'(bus.done_with_window_data), 64'd0);
        checkOutput("resetDoneDesc", 64'(bus.done_with_desc_data), 64'd0);
        checkOutput("resetRow0", 64'(bus.accRowTotal[0]), 64'd0);
        checkOutput("resetRow15", 64'(bus.accRowTotal[15]), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idleNCC", 64'(bus.greatestNCC), mBest);

        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                curPat[r][c] = 8'(3 + c % 4);
        loadDescriptor(20);
        waitDrain(200);

        fillWin(0, 2); applyStimulus(1'b1); waitDrain(100);
        fillWin(0, 0); applyStimulus(1'b1); waitDrain(100);
        fillWin(1, 1); applyStimulus(1'b1); waitDrain(100);

        fillWin(2, 0); applyStimulus(1'b1);
        repeat (28) @(negedge clk);
        strayPulse();
        waitDrain(100);

        fillWin(1, 2); applyStimulus(1'b1); waitDrain(100);

        fillWin(2, 0); applyStimulus(1'b0);
        repeat (10) @(negedge clk);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                curPat[r][c] = 8'($urandom_range(0, 255));
        loadDescriptor(-1);
        waitDrain(200);
        checkOutput("reloadNCC", 64'(bus.greatestNCC), mBest);
        checkOutput("reloadIndex", 64'(bus.greatestWinIndex), 64'(mIdx));

        for (int i = 0; i < 6; i++) begin
            fillWin(2, 0); applyStimulus(1'b1); waitDrain(100);
        end
        fillWin(1, 1); applyStimulus(1'b1); waitDrain(100);

        fillWin(2, 0); applyStimulus(1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midResetNCC", 64'(bus.greatestNCC), 64'd0);
        checkOutput("midResetIndex", 64'(bus.greatestWinIndex), 64'd0);
        checkOutput("midResetRow3", 64'(bus.accRowTotal[3]), 64'd0);
        fillWin(0, 0);
        mDesc   = curWin;
        mBest   = '0;
        mIdx    = 0;
        mWinCnt = 0;
        @(negedge clk);
        rst = 1'b0;
        fillWin(2, 0); applyStimulus(1'b1); waitDrain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ncc.md
Name: ncc

Overview:
- Normalized-cross-correlation scorer for the vision feature tracker.
- Loads a 16x16 8-bit descriptor patch, streamed 4 pixels per cycle.
- Scores a sequence of 16x16 candidate windows, each presented in parallel, against that patch.
- Tracks the best score and the index of the window that produced it.

Parameters:
- DIM, 16, patch/window side in pixels.
- PIX_W, 8, pixel width.
- IDX_W, 9, window index width (512 windows per search).
- FRAC_W, 54, fractional bits of the score.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- window_data_ready  in  1  one-cycle pulse; windowIn is valid
- desc_data_ready  in  1  high while descriptor words are streamed
- descIn  in  32  4 descriptor pixels; [31:24] is the lowest column
- windowIn  in  16x16x8  unpacked [row][col] window pixels
- done_with_window_data  out  1  one-cycle pulse when a window's score is folded in
- done_with_desc_data  out  1  one-cycle pulse when the 64th descriptor word is captured
- greatestNCC  out  64 [9:-54]  best squared NCC so far, unsigned Q10.54
- greatestWinIndex  out  9  index of the best window
- accRowTotal  out  16x32  per-row dot products of the last window

Behaviour:
- Reset: all outputs 0, descriptor RAM 0, state IDLE, word counter 0, window counter 0.

Descriptor load:
- Each cycle with desc_data_ready=1, word k (k = 0..63) is stored at row k/4, cols 4*(k%4)..4*(k%4)+3.
- descSumOfSquares (32b) accumulates the squares of all 4 bytes each cycle.
- On k=63: pulse done_with_desc_data, zero the counter, clear greatestNCC/greatestWinIndex and the window counter.
- desc_data_ready deasserting mid-load holds the counter; loading resumes later.
- A new load starting while a window is in flight aborts that window.

Window pipeline (states IDLE, ROW, SUM, MUL, DIV, CMP):
- IDLE + window_data_ready: latch windowIn, go to ROW. window_data_ready in any other state is ignored.
- ROW (1 cycle): accRowTotal[r] = sum over c of d[r][c]*w[r][c]; also per-row window sum of squares.
- SUM: accPatchSum = sum of the 16 row totals; winSumOfSquares = sum of the row squares.
- MUL: numeratorLog2 = accPatchSum^2 (48b); denomLog2 = descSumOfSquares * winSumOfSquares (64b).
- DIV: restoring divider, 1 quotient bit per cycle, 64 cycles. score = (num^2 << 54) / den, truncated.
  - Division by zero is forbidden: if den = 0, score = 0.
- CMP: if score > greatestNCC, update greatestNCC and greatestWinIndex = window counter.
  - Ties keep the earlier index; window 0 always replaces the initial 0 unless its score is 0.
  - Increment the window counter (wraps at 512), pulse done_with_window_data, return to IDLE.
- Latency: window_data_ready to done_with_window_data = 69 cycles.
- accRowTotal is valid from the cycle after ROW and holds until the next window.
- Inputs are unsigned, so the score is in [0, 1.0].
- Reset mid-operation aborts and clears everything.

Decomposition:
- Package ncc_pkg: DIM, PIX_W, IDX_W, FRAC_W; typedef pixel_t (8b); typedef row_t (pixel_t [DIM]); typedef score_t (bit [9:-54]); state enum.
- Sub-module ncc_row_pe, instantiated 16 times: combinational 16-way multiply-accumulate giving the dot product and the window sum of squares for one row.

Test Plan:
- Reset, then idle: all outputs 0, no done pulses.
- Stream 64 words of {3,4,5,6} -> done_with_desc_data pulses on the 64th word; descSumOfSquares = 5504.
- Then present a window of all 2s:
  - accRowTotal[0..15] = 144 after ROW; accPatchSum = 2304; winSumOfSquares = 1024.
  - After 69 cycles: greatestNCC ≈ 0.941853 (5308416*2^54 / 5636096, truncated); greatestWinIndex = 0; done pulse.
- Second window of all zeros -> den = 0, score 0; greatestNCC unchanged; index stays 0.
- Third window equal to the descriptor pattern -> score = 1.0 (0x0040_0000_0000_0000); greatestWinIndex = 2.
- window_data_ready pulsed during DIV -> ignored; the window counter advances only once.
- Reload the descriptor -> greatestNCC and greatestWinIndex return to 0.
